// File: rtl/muxpga_cfg_loader_if.sv
// Configuration word stream for the mux-cell array loader.
// The master drives the words; the loader answers with a registered ready.
interface muxpga_cfg_loader_if #(
  parameter int CFG_W = 5
);
  logic [CFG_W-1:0] cfg_data;
  logic             cfg_valid;
  logic             cfg_ready;

  modport master (output cfg_data, output cfg_valid, input cfg_ready);
  modport slave  (input cfg_data, input cfg_valid, output cfg_ready);
endinterface

// File: rtl/muxpga_cfg_loader.sv
// Loads one config word per cell plus an XOR checksum into a shadow store and
// commits the shadow to the active store atomically when the checksum matches.
//
// state | meaning
// IDLE  | after reset, waiting for start
// LOAD  | accepting cell words into the shadow store
// CHECK | accepting the checksum word
// RUN   | active config committed, array running
// ERR   | last load failed its checksum
module muxpga_cfg_loader #(
  parameter  int ROWS  = 8,
  parameter  int COLS  = 8,
  parameter  int CFG_W = 5,
  localparam int N     = ROWS * COLS,
  localparam int AW    = $clog2(N)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  muxpga_cfg_loader_if.slave   cfg,
  output logic [N*CFG_W-1:0]   cell_cfg,
  output logic                 array_run,
  output logic                 cfg_err,
  output logic                 busy,
  output logic [AW-1:0]        load_addr
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_CHECK = 3'd2,
    S_RUN   = 3'd3,
    S_ERR   = 3'd4
  } state_t;

  state_t               state, state_nx;
  logic [N*CFG_W-1:0]   shadow_q;
  logic [N*CFG_W-1:0]   active_q;
  logic [CFG_W-1:0]     chk_q;
  logic [AW-1:0]        addr_q;
  logic                 run_q;
  logic                 err_q;
  logic                 xfer;
  logic                 last_word;
  logic                 chk_ok;

  // ready decodes only the state register, so xfer has no path from valid to ready
  assign xfer      = cfg.cfg_valid && cfg.cfg_ready;
  assign last_word = (addr_q == AW'(N - 1));
  assign chk_ok    = (cfg.cfg_data == chk_q);

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    if (start) begin
      state_nx = S_LOAD;
    end else begin
      case (state)
        S_LOAD:  if (xfer && last_word) state_nx = S_CHECK;
        S_CHECK: if (xfer) state_nx = chk_ok ? S_RUN : S_ERR;
        default: state_nx = state;
      endcase
    end
  end

  always_comb begin
    cfg.cfg_ready = (state == S_LOAD) || (state == S_CHECK);
    busy          = (state == S_LOAD) || (state == S_CHECK);
    array_run     = run_q;
    cfg_err       = err_q;
    cell_cfg      = active_q;
    load_addr     = addr_q;
  end

  // start wins over a same-cycle transfer; run_q keeps the old config live during reloads
  always_ff @(posedge clk) begin
    if (reset) begin
      shadow_q <= '0;
      active_q <= '0;
      chk_q    <= '0;
      addr_q   <= '0;
      run_q    <= 1'b0;
      err_q    <= 1'b0;
    end else if (start) begin
      chk_q  <= '0;
      addr_q <= '0;
      err_q  <= 1'b0;
    end else if (xfer) begin
      if (state == S_LOAD) begin
        shadow_q[addr_q*CFG_W +: CFG_W] <= cfg.cfg_data;
        chk_q  <= chk_q ^ cfg.cfg_data;
        addr_q <= last_word ? '0 : addr_q + AW'(1);
      end else if (state == S_CHECK) begin
        if (chk_ok) begin
          active_q <= shadow_q;
          run_q    <= 1'b1;
        end else begin
          run_q <= 1'b0;
          err_q <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_muxpga_cfg_loader.sv
// Scoreboard bench for muxpga_cfg_loader: expected commit results are queued when
// the checksum is driven and compared when the loader leaves CHECK.
module tb_muxpga_cfg_loader;
  localparam int CFG_W = 5;
  localparam int N     = 64;
  localparam int AW    = 6;
  localparam int VW    = N * CFG_W;

  typedef struct {
    logic [VW-1:0] cfg;
    logic          run;
    logic          err;
  } exp_t;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [VW-1:0] cell_cfg;
  logic          array_run;
  logic          cfg_err;
  logic          busy;
  logic [AW-1:0] load_addr;

  muxpga_cfg_loader_if #(.CFG_W(CFG_W)) bus ();

  muxpga_cfg_loader #(.ROWS(8), .COLS(8), .CFG_W(CFG_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .cfg       (bus.slave),
    .cell_cfg  (cell_cfg),
    .array_run (array_run),
    .cfg_err   (cfg_err),
    .busy      (busy),
    .load_addr (load_addr)
  );

  always #5 clk = ~clk;

  int             n_chk  = 0;
  int             n_pass = 0;
  logic [CFG_W-1:0] words [N];
  logic [VW-1:0]  shadow_m = '0;
  logic [VW-1:0]  active_m = '0;
  logic           run_m = 1'b0;
  logic           err_m = 1'b0;
  exp_t           sb [$];

  task automatic chk_val(input string tag, input logic [VW-1:0] obs, input logic [VW-1:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic xfer(input logic [CFG_W-1:0] d);
    int n = 0;
    bus.cfg_data  = d;
    bus.cfg_valid = 1'b1;
    while (!bus.cfg_ready && n < 20) begin
      tick();
      n++;
    end
    if (!bus.cfg_ready) chk_val("xfer_ready", VW'(bus.cfg_ready), VW'(1));
    tick();
    bus.cfg_valid = 1'b0;
  endtask

  task automatic run_load(input logic [CFG_W-1:0] csum, input bit do_start, input bit gaps);
    logic [CFG_W-1:0] c = '0;
    exp_t e;
    exp_t got;
    int   n = 0;
    if (do_start) pulse_start();
    chk_val("busy_in_load", VW'(busy), VW'(1));
    chk_val("err_cleared", VW'(cfg_err), VW'(0));
    for (int i = 0; i < N; i++) begin
      if (gaps && $urandom_range(0, 1) == 1) begin
        bus.cfg_valid = 1'b0;
        repeat ($urandom_range(1, 3)) tick();
        chk_val("addr_hold_gap", VW'(load_addr), VW'(i));
      end
      xfer(words[i]);
      shadow_m[i*CFG_W +: CFG_W] = words[i];
      c ^= words[i];
    end
    chk_val("addr_wrap", VW'(load_addr), VW'(0));
    chk_val("old_cfg_held", cell_cfg, active_m);
    chk_val("run_held", VW'(array_run), VW'(run_m));
    if (csum == c) begin
      active_m = shadow_m;
      run_m    = 1'b1;
      err_m    = 1'b0;
    end else begin
      run_m = 1'b0;
      err_m = 1'b1;
    end
    e.cfg = active_m;
    e.run = run_m;
    e.err = err_m;
    sb.push_back(e);
    xfer(csum);
    while (busy && n < 5) begin
      tick();
      n++;
    end
    chk_val("busy_done", VW'(busy), VW'(0));
    chk_val("ready_done", VW'(bus.cfg_ready), VW'(0));
    got = sb.pop_front();
    chk_val("commit_cfg", cell_cfg, got.cfg);
    chk_val("commit_run", VW'(array_run), VW'(got.run));
    chk_val("commit_err", VW'(cfg_err), VW'(got.err));
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk_val({tag, "_cell_cfg"}, cell_cfg, '0);
    chk_val({tag, "_run"},   VW'(array_run), VW'(0));
    chk_val({tag, "_err"},   VW'(cfg_err), VW'(0));
    chk_val({tag, "_ready"}, VW'(bus.cfg_ready), VW'(0));
    chk_val({tag, "_busy"},  VW'(busy), VW'(0));
    chk_val({tag, "_addr"},  VW'(load_addr), VW'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [VW-1:0] all3;
    reset         = 1'b1;
    start         = 1'b0;
    bus.cfg_data  = '0;
    bus.cfg_valid = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    chk_reset_outputs("reset");

    // ramp pattern, correct checksum
    for (int i = 0; i < N; i++) words[i] = CFG_W'(i);
    run_load(5'h00, 1'b1, 1'b0);
    chk_val("cell37", VW'(cell_cfg[37*CFG_W +: CFG_W]), VW'(5'h05));

    // same stream, bad checksum
    run_load(5'h01, 1'b1, 1'b0);

    // different content, bad checksum: active must keep the ramp
    for (int i = 0; i < N; i++) words[i] = ~CFG_W'(i);
    run_load(5'h01, 1'b1, 1'b0);
    chk_val("ramp_kept_c37", VW'(cell_cfg[37*CFG_W +: CFG_W]), VW'(5'h05));

    // recommit ramp, then partial load interrupted by start with valid high
    for (int i = 0; i < N; i++) words[i] = CFG_W'(i);
    run_load(5'h00, 1'b1, 1'b0);
    pulse_start();
    for (int i = 0; i < 30; i++) begin
      xfer(5'h1F);
      shadow_m[i*CFG_W +: CFG_W] = 5'h1F;
    end
    chk_val("partial_addr", VW'(load_addr), VW'(30));
    chk_val("partial_old_cfg", cell_cfg, active_m);
    chk_val("partial_run", VW'(array_run), VW'(1));
    start         = 1'b1;
    bus.cfg_valid = 1'b1;
    bus.cfg_data  = 5'h1F;
    tick();
    start         = 1'b0;
    bus.cfg_valid = 1'b0;
    chk_val("restart_addr", VW'(load_addr), VW'(0));
    for (int i = 0; i < N; i++) words[i] = 5'h03;
    run_load(5'h00, 1'b0, 1'b0);
    all3 = {N{5'h03}};
    chk_val("all_cells_03", cell_cfg, all3);

    // valid gaps
    for (int i = 0; i < N; i++) words[i] = 5'h10;
    run_load(5'h00, 1'b1, 1'b1);

    // reset in the middle of a load
    for (int i = 0; i < N; i++) words[i] = CFG_W'(i + 7);
    pulse_start();
    for (int i = 0; i < 40; i++) xfer(words[i]);
    chk_val("addr_40", VW'(load_addr), VW'(40));
    reset = 1'b1;
    tick();
    tick();
    reset    = 1'b0;
    active_m = '0;
    shadow_m = '0;
    run_m    = 1'b0;
    err_m    = 1'b0;
    chk_reset_outputs("midreset");

    // valid while not ready is ignored
    bus.cfg_valid = 1'b1;
    bus.cfg_data  = 5'h0A;
    repeat (3) tick();
    bus.cfg_valid = 1'b0;
    chk_val("idle_addr", VW'(load_addr), VW'(0));
    chk_val("idle_busy", VW'(busy), VW'(0));

    if (sb.size() != 0) chk_val("sb_empty", VW'(sb.size()), VW'(0));
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
